qmux_seq: RTL and testbench
===========================

# qmux_seq

Parametrised successor to the single-select quadrant clock mux. It selects one of NUM_SRC clock/gating sources onto the quadrant net under a request/acknowledge handshake. Every change of source is sequenced as gate-off, switch, settle, gate-on, so the output never glitches between sources. It sits between the global clock network and the quadrant HSCK spine, with the select controlled by fabric logic in the QCK domain.

## Interface
Parameters:
- NUM_SRC, 4: number of selectable sources (2..16).
- SEL_W, 2: select width; must satisfy 2^SEL_W >= NUM_SRC.
- GAP_CYCLES, 2: QCK cycles for the gate-off phase and again for the settle phase (>= 1).
- DEFAULT_SEL, 0: source selected after reset (< NUM_SRC).

Ports:
- QCK, input, 1: control clock; all state changes on its rising edge.
- QRT, input, 1: reset, synchronous, active-high.
- SRC_IN, input, NUM_SRC: candidate sources; bit i is source i.
- REQ_VALID, input, 1: switch request valid.
- REQ_SEL, input, SEL_W: requested source index.
- REQ_READY, output, 1: controller can accept a request.
- DONE, output, 1: one-cycle pulse when a request completes.
- ERR, output, 1: one-cycle pulse when a request is rejected.
- CUR_SEL, output, SEL_W: currently connected source.
- GATE_EN, output, 1: output gate enable.
- IZ, output, 1: muxed output, defined as GATE_EN & SRC_IN[CUR_SEL].

## Operation
- Reset values:
  - state IDLE
  - CUR_SEL = DEFAULT_SEL
  - GATE_EN = 1
  - REQ_READY = 1
  - DONE = 0, ERR = 0
  - counter = 0
- Accept rule: a request is accepted on an edge where REQ_VALID & REQ_READY. REQ_READY = 1 only in IDLE.
- Accepted request handling, evaluated in priority order:
  - REQ_SEL >= NUM_SRC: rejected. ERR pulses the next cycle. Stay IDLE, no other change.
  - REQ_SEL == CUR_SEL: DONE pulses the next cycle. Stay IDLE, no gating.
  - Otherwise: latch REQ_SEL as target, load counter = GAP_CYCLES-1, GATE_EN <= 0, go to GATE_OFF.
- States:
  - IDLE: GATE_EN = 1; waits for a request.
  - GATE_OFF: GATE_EN = 0. Decrement the counter each cycle. At counter == 0: CUR_SEL <= target, reload counter = GAP_CYCLES-1, go to SETTLE.
  - SETTLE: GATE_EN = 0. Decrement the counter. At counter == 0: GATE_EN <= 1, DONE <= 1, go to IDLE.
- Counter width is clog2(GAP_CYCLES) with a minimum of 1. It never wraps, because it is only loaded, then decremented until it reaches 0.
- REQ_VALID/REQ_SEL outside IDLE are ignored; requesters must hold REQ_VALID until they see REQ_READY.
- CUR_SEL is registered. IZ is combinational from registered GATE_EN/CUR_SEL and the live SRC_IN.
- Values 2^SEL_W > REQ_SEL >= NUM_SRC never reach CUR_SEL.

## Timing
- Switch accepted at edge of cycle T (numbering for GAP_CYCLES = G):
  - cycles T+1..T+2G: GATE_EN = 0
  - cycle T+G+1: CUR_SEL shows the new value
  - cycle T+2G+1: GATE_EN = 1, DONE = 1, REQ_READY = 1
  - total latency 2G+1 cycles
- Same-select or invalid request: DONE or ERR at T+1; REQ_READY stays 1. Back-to-back requests can be accepted every cycle.
- A new switch request can be accepted in the cycle DONE is high.
- DONE and ERR are never high together, and each lasts exactly one cycle.
- QRT high at any edge, including mid-switch: next cycle returns to reset values (CUR_SEL = DEFAULT_SEL, GATE_EN = 1, state IDLE). The in-flight request is dropped with no DONE.
- QRT takes priority over a simultaneous request.
- IZ is 0 throughout gate-off/settle, whatever SRC_IN does.

## Test plan
- Reset: with NUM_SRC=4, DEFAULT_SEL=0, GAP_CYCLES=2, hold QRT for 2 cycles, then release. Required: CUR_SEL=0, GATE_EN=1, REQ_READY=1, DONE=ERR=0; IZ tracks SRC_IN[0].
- Normal switch: REQ_SEL=2 accepted at cycle 0.
  - GATE_EN=0 in cycles 1-4.
  - CUR_SEL=2 from cycle 3.
  - cycle 5: GATE_EN=1, DONE=1.
  - IZ=0 in cycles 1-4 with SRC_IN toggling every cycle; IZ follows SRC_IN[2] from cycle 5.
- Invalid and redundant requests:
  - REQ_SEL=5 with SEL_W=3, NUM_SRC=4: ERR=1 at next cycle, CUR_SEL unchanged.
  - REQ_SEL=CUR_SEL: DONE=1 at next cycle, GATE_EN stays 1.
- Busy handshake: during a switch to 1, hold REQ_VALID with REQ_SEL=3. Required: REQ_READY=0 in cycles 1-4 and the request is not taken. It is accepted in cycle 5 (DONE for 1 in the same cycle). A second DONE follows at cycle 10, with CUR_SEL=3.
- Reset mid-switch: assert QRT in cycle 3 of a switch to 2. Required: from cycle 4, CUR_SEL=0, GATE_EN=1, REQ_READY=1, and no DONE.
- GAP_CYCLES=1 with NUM_SRC=2: a switch takes 3 cycles. GATE_EN is low in cycles 1-2, CUR_SEL updates at cycle 2, and DONE fires at cycle 3.

Source files
------------

// File: rtl/qmux_seq.sv
// qmux_seq: sequenced quadrant clock mux.
// Selects one of NUM_SRC sources onto the quadrant net. Every change of source
// runs gate-off, switch, settle, gate-on, so the output never carries a
// partial pulse from either source while the select moves.
module qmux_seq #(
  parameter int NUM_SRC     = 4,
  parameter int SEL_W       = 2,
  parameter int GAP_CYCLES  = 2,
  parameter int DEFAULT_SEL = 0
) (
  input  logic               QCK,
  input  logic               QRT,
  input  logic [NUM_SRC-1:0] SRC_IN,
  input  logic               REQ_VALID,
  input  logic [SEL_W-1:0]   REQ_SEL,
  output logic               REQ_READY,
  output logic               DONE,
  output logic               ERR,
  output logic [SEL_W-1:0]   CUR_SEL,
  output logic               GATE_EN,
  output logic               IZ
);

  localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(GAP_CYCLES - 1);
  // One extra bit so NUM_SRC == 2^SEL_W is representable.
  localparam logic [SEL_W:0]   NUM_SRC_EXT = (SEL_W + 1)'(NUM_SRC);
  localparam logic [SEL_W-1:0] SEL_RST     = SEL_W'(DEFAULT_SEL);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE_OFF,
    S_SETTLE
  } state_e;

  state_e           r_state,   w_state_nxt;
  logic [SEL_W-1:0] r_cur_sel, w_cur_sel_nxt;
  logic [SEL_W-1:0] r_target,  w_target_nxt;
  logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
  logic             r_gate_en, w_gate_en_nxt;
  logic             r_done,    w_done_nxt;
  logic             r_err,     w_err_nxt;
  logic             w_src_sel;

  // Next-state, counter and pulse generation for the switch sequence.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    w_state_nxt   = r_state;
    w_cur_sel_nxt = r_cur_sel;
    w_target_nxt  = r_target;
    w_cnt_nxt     = r_cnt;
    w_gate_en_nxt = r_gate_en;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (REQ_VALID) begin
          if ({1'b0, REQ_SEL} >= NUM_SRC_EXT) begin
            w_err_nxt = 1'b1;
          end else if (REQ_SEL == r_cur_sel) begin
            w_done_nxt = 1'b1;
          end else begin
            w_target_nxt  = REQ_SEL;
            w_cnt_nxt     = CNT_LOAD;
            w_gate_en_nxt = 1'b0;
            w_state_nxt   = S_GATE_OFF;
          end
        end
      end
      S_GATE_OFF: begin
        if (r_cnt == '0) begin
          w_cur_sel_nxt = r_target;
          w_cnt_nxt     = CNT_LOAD;
          w_state_nxt   = S_SETTLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_gate_en_nxt = 1'b1;
          w_done_nxt    = 1'b1;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_gate_en_nxt = 1'b1;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; a reset drops any in-flight switch.
  always_ff @(posedge QCK) begin
    // NOTE: non-blocking assignments so every register samples the values of
    // the previous cycle, independent of statement order.
    if (QRT) begin
      r_state   <= S_IDLE;
      r_cur_sel <= SEL_RST;
      r_target  <= SEL_RST;
      r_cnt     <= '0;
      r_gate_en <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cur_sel <= w_cur_sel_nxt;
      r_target  <= w_target_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gate_en <= w_gate_en_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Pick the live source bit; select values outside NUM_SRC cannot occur but read as 0.
  always_comb begin
    w_src_sel = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (r_cur_sel == SEL_W'(i)) w_src_sel = SRC_IN[i];
    end
  end

  // The gate has its own flop rather than a state decode: the
  // GATE_OFF->SETTLE transition flips two state bits and a decode could
  // momentarily see IDLE and open the gate.
  assign GATE_EN   = r_gate_en;
  assign CUR_SEL   = r_cur_sel;
  assign REQ_READY = (r_state == S_IDLE);
  assign DONE      = r_done;
  assign ERR       = r_err;
  assign IZ        = r_gate_en & w_src_sel;

endmodule

// File: tb/tb_qmux_seq.sv
// Testbench for qmux_seq. Two instances: d0 (NUM_SRC=4, SEL_W=3, GAP=2) and
// d1 (NUM_SRC=2, SEL_W=1, GAP=1). Expected outputs come from a timeline model
// that records when each switch was accepted and derives every output from
// that cycle number.
module tb_qmux_seq;

  logic       QCK;
  logic [1:0] qrt;
  logic [1:0] req_valid;
  logic [2:0] req_sel_a;
  logic       req_sel_b;
  logic [3:0] src_a;
  logic [1:0] src_b;

  logic       ready_a, done_a, err_a, gate_a, iz_a;
  logic [2:0] cur_a;
  logic       ready_b, done_b, err_b, gate_b, iz_b;
  logic       cur_b;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Timeline model state per instance.
  int m_sel     [2];
  int m_new     [2];
  int m_t0      [2];
  int m_done_at [2];
  int m_err_at  [2];
  bit m_active  [2];

  qmux_seq #(.NUM_SRC(4), .SEL_W(3), .GAP_CYCLES(2), .DEFAULT_SEL(0)) u_dut_a (
    .QCK       (QCK),
    .QRT       (qrt[0]),
    .SRC_IN    (src_a),
    .REQ_VALID (req_valid[0]),
    .REQ_SEL   (req_sel_a),
    .REQ_READY (ready_a),
    .DONE      (done_a),
    .ERR       (err_a),
    .CUR_SEL   (cur_a),
    .GATE_EN   (gate_a),
    .IZ        (iz_a)
  );

  qmux_seq #(.NUM_SRC(2), .SEL_W(1), .GAP_CYCLES(1), .DEFAULT_SEL(0)) u_dut_b (
    .QCK       (QCK),
    .QRT       (qrt[1]),
    .SRC_IN    (src_b),
    .REQ_VALID (req_valid[1]),
    .REQ_SEL   (req_sel_b),
    .REQ_READY (ready_b),
    .DONE      (done_b),
    .ERR       (err_b),
    .CUR_SEL   (cur_b),
    .GATE_EN   (gate_b),
    .IZ        (iz_b)
  );

  initial QCK = 1'b0;
  always #5 QCK = ~QCK;

  function automatic int num_src(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic int gap(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_active[d]  = 1'b0;
    m_sel[d]     = 0;
    m_new[d]     = 0;
    m_t0[d]      = 0;
    m_done_at[d] = -1;
    m_err_at[d]  = -1;
  endtask

  // Compare one instance against the model for the current cycle.
  task automatic check_dut(input int d);
    int   e_sel;
    bit   e_busy;
    logic a_ready, a_done, a_err, a_gate, a_iz, a_src;
    int   a_sel;
    e_busy = m_active[d];
    e_sel  = (m_active[d] && cyc >= m_t0[d] + gap(d) + 1) ? m_new[d] : m_sel[d];
    if (d == 0) begin
      a_ready = ready_a; a_done = done_a; a_err = err_a; a_gate = gate_a;
      a_iz = iz_a; a_sel = int'(cur_a); a_src = src_a[e_sel];
    end else begin
      a_ready = ready_b; a_done = done_b; a_err = err_b; a_gate = gate_b;
      a_iz = iz_b; a_sel = int'(cur_b); a_src = src_b[e_sel];
    end
    check($sformatf("d%0d c%0d ready", d, cyc), 32'(a_ready), 32'(!e_busy));
    check($sformatf("d%0d c%0d gate", d, cyc), 32'(a_gate), 32'(!e_busy));
    check($sformatf("d%0d c%0d done", d, cyc), 32'(a_done), 32'(cyc == m_done_at[d]));
    check($sformatf("d%0d c%0d err", d, cyc), 32'(a_err), 32'(cyc == m_err_at[d]));
    check($sformatf("d%0d c%0d cur_sel", d, cyc), 32'(a_sel), 32'(e_sel));
    check($sformatf("d%0d c%0d iz", d, cyc), 32'(a_iz), 32'(!e_busy && a_src));
  endtask

  // Apply the request rules for the edge that ends the current cycle.
  task automatic model_edge(input int d);
    int s;
    s = (d == 0) ? int'(req_sel_a) : int'(req_sel_b);
    if (qrt[d]) begin
      model_reset(d);
    end else if (req_valid[d] && !m_active[d]) begin
      if (s >= num_src(d)) begin
        m_err_at[d] = cyc + 1;
      end else if (s == m_sel[d]) begin
        m_done_at[d] = cyc + 1;
      end else begin
        m_active[d]  = 1'b1;
        m_new[d]     = s;
        m_t0[d]      = cyc;
        m_done_at[d] = cyc + 2 * gap(d) + 1;
      end
    end
  endtask

  // Retire a switch once its full latency has elapsed.
  task automatic model_advance(input int d);
    if (m_active[d] && cyc >= m_t0[d] + 2 * gap(d) + 1) begin
      m_sel[d]    = m_new[d];
      m_active[d] = 1'b0;
    end
  endtask

  // One cycle: new source values, check, model the edge, move to next negedge.
  task automatic tick();
    src_a = 4'($urandom);
    src_b = 2'($urandom);
    #1;
    for (int d = 0; d < 2; d++) check_dut(d);
    for (int d = 0; d < 2; d++) model_edge(d);
    @(posedge QCK);
    cyc++;
    for (int d = 0; d < 2; d++) model_advance(d);
    @(negedge QCK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    qrt       = 2'b11;
    req_valid = 2'b00;
    req_sel_a = 3'd0;
    req_sel_b = 1'b0;
    src_a     = 4'd0;
    src_b     = 2'd0;
    for (int d = 0; d < 2; d++) model_reset(d);
    @(negedge QCK);

    // Reset held two cycles, then released.
    tick();
    tick();
    qrt = 2'b00;
    idle(2);

    // Normal switch: d0 to 2 (5-cycle sequence), d1 to 1 (3-cycle sequence).
    req_valid = 2'b11;
    req_sel_a = 3'd2;
    req_sel_b = 1'b1;
    tick();
    req_valid = 2'b00;
    idle(6);

    // Out-of-range select, then a request for the current select.
    req_valid[0] = 1'b1; req_sel_a = 3'd5; tick();
    req_valid[0] = 1'b0; tick();
    req_valid[0] = 1'b1; req_sel_a = 3'd2; tick();
    req_valid[0] = 1'b0; tick();

    // Busy handshake: switch to 1, then hold a request for 3 until taken.
    req_valid[0] = 1'b1; req_sel_a = 3'd1; tick();
    req_sel_a = 3'd3;
    idle(5);
    req_valid[0] = 1'b0;
    idle(8);

    // Reset in cycle 3 of a switch to 2.
    req_valid[0] = 1'b1; req_sel_a = 3'd2; tick();
    req_valid[0] = 1'b0;
    idle(2);
    qrt[0] = 1'b1; tick();
    qrt[0] = 1'b0;
    idle(4);

    // Reset wins over a simultaneous request.
    qrt = 2'b11; req_valid = 2'b11; req_sel_a = 3'd1; req_sel_b = 1'b1; tick();
    qrt = 2'b00; req_valid = 2'b00;
    idle(2);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      for (int d = 0; d < 2; d++) begin
        qrt[d]       = ($urandom_range(0, 59) == 0);
        req_valid[d] = ($urandom_range(0, 2) != 0);
      end
      req_sel_a = 3'($urandom_range(0, 5));
      req_sel_b = 1'($urandom);
      tick();
    end
    qrt       = 2'b00;
    req_valid = 2'b00;
    idle(6);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
